// File: rtl/alu4_pkg.sv
// Shared definitions for the alu_4 BIST driver: opcodes, vector layout,
// FSM states and the reference behaviour of the 4-bit ALU.
package alu4_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Field order makes the packed value equal to the sweep index, b in the LSBs.
  typedef struct packed {
    logic       cci;
    logic [1:0] f;
    logic [3:0] a;
    logic [3:0] b;
  } alu4_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } alu4_state_e;

  // Returns {co,d}; SUB carry-out of 1 means no borrow.
  function automatic logic [4:0] alu4_model(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [1:0] f,
                                            input logic       cci);
    logic [4:0] res;
    case (f)
      OP_ADD:  res = {1'b0, a} + {1'b0, b} + {4'b0000, cci};
      OP_SUB:  res = {1'b0, a} + {1'b0, ~b} + {4'b0000, cci};
      OP_AND:  res = {1'b0, a & b};
      default: res = {1'b0, a | b};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu4_bist_checker.sv
// Combinational compare of the ALU response against the reference model
// for the vector currently being driven.
module alu4_bist_checker
  import alu4_pkg::*;
(
  input  alu4_vec_t  vec_i,
  input  logic [3:0] alu_d_i,
  input  logic       alu_co_i,
  output logic       mismatch_o
);

  logic [4:0] expected;

  assign expected   = alu4_model(vec_i.a, vec_i.b, vec_i.f, vec_i.cci);
  assign mismatch_o = (expected != {alu_co_i, alu_d_i});

endmodule

// File: rtl/alu4_bist_driver.sv
// Exhaustive BIST sequencer for the 4-bit ALU: sweeps all 2048 vectors,
// counts mismatches and records the first failing vector and response.
module alu4_bist_driver
  import alu4_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3,
  parameter int ERR_W         = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_f,
  output logic             alu_cci,
  input  logic [3:0]       alu_d,
  input  logic             alu_co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [10:0]      fail_vec,
  output logic [3:0]       fail_d,
  output logic             fail_co
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [10:0]      LAST_IDX    = 11'h7FF;

  alu4_state_e      state_q;
  alu4_vec_t        vec_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             first_seen_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [10:0]      fail_vec_q;
  logic [3:0]       fail_d_q;
  logic             fail_co_q;
  logic             mismatch;

  alu4_bist_checker u_checker (
    .vec_i      (vec_q),
    .alu_d_i    (alu_d),
    .alu_co_i   (alu_co),
    .mismatch_o (mismatch)
  );

  assign err_d = (mismatch && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;

  // Abort outranks both start and the CHECK update; drive registers and
  // results are deliberately left untouched so they can be inspected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      first_seen_q <= 1'b0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_d_q     <= '0;
      fail_co_q    <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_SETTLE;
            vec_q        <= '0;
            cnt_q        <= SETTLE_LOAD;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            first_seen_q <= 1'b0;
            err_q        <= '0;
            fail_vec_q   <= '0;
            fail_d_q     <= '0;
            fail_co_q    <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_CHECK: begin
          err_q <= err_d;
          if (mismatch && !first_seen_q) begin
            first_seen_q <= 1'b1;
            fail_vec_q   <= vec_q;
            fail_d_q     <= alu_d;
            fail_co_q    <= alu_co;
          end
          if (vec_q == LAST_IDX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= ST_SETTLE;
            vec_q   <= alu4_vec_t'(vec_q + 11'd1);
            cnt_q   <= SETTLE_LOAD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a     = vec_q.a;
  assign alu_b     = vec_q.b;
  assign alu_f     = vec_q.f;
  assign alu_cci   = vec_q.cci;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_vec_q;
  assign fail_d    = fail_d_q;
  assign fail_co   = fail_co_q;

endmodule
